// File: rtl/instr_stream_encoder_pkg.sv
// Shared definitions for the instruction stream encoder: mnemonic codes,
// MIPS opcode/funct fields, FSM states and the word-packing function.
package instr_stream_encoder_pkg;

  typedef enum logic [5:0] {
    M_ADDU  = 6'd0,  M_SUBU  = 6'd1,  M_AND   = 6'd2,  M_OR    = 6'd3,
    M_XOR   = 6'd4,  M_NOR   = 6'd5,  M_SLT   = 6'd6,  M_SLTU  = 6'd7,
    M_SLL   = 6'd8,  M_SRL   = 6'd9,  M_SRA   = 6'd10, M_JR    = 6'd11,
    M_ADDIU = 6'd12, M_SLTI  = 6'd13, M_SLTIU = 6'd14, M_ANDI  = 6'd15,
    M_ORI   = 6'd16, M_XORI  = 6'd17, M_LUI   = 6'd18, M_LW    = 6'd19,
    M_SW    = 6'd20, M_LB    = 6'd21, M_LBU   = 6'd22, M_SB    = 6'd23,
    M_BEQ   = 6'd24, M_BNE   = 6'd25, M_BLEZ  = 6'd26, M_BGTZ  = 6'd27,
    M_BLTZ  = 6'd28, M_BGEZ  = 6'd29, M_J     = 6'd30, M_JAL   = 6'd31
  } mnem_e;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0a;
  localparam logic [5:0] OP_SLTIU  = 6'h0b;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_XORI   = 6'h0e;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SW     = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] word;
  } enc_t;

  function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] pack_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic is_branch(input logic [5:0] m);
    logic b;
    case (m)
      M_BEQ, M_BNE, M_BLEZ, M_BGTZ, M_BLTZ, M_BGEZ: b = 1'b1;
      default:                                      b = 1'b0;
    endcase
    return b;
  endfunction

  // Unused fields of each format are forced to zero; unknown codes come back invalid.
  function automatic enc_t encode_instr(input logic [5:0] m, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] shamt, input logic [15:0] imm,
                                        input logic [25:0] target);
    enc_t e;
    e.valid = 1'b1;
    e.word  = 32'h0000_0000;
    case (m)
      M_ADDU:  e.word = pack_r(rs, rt, rd, 5'd0, FN_ADDU);
      M_SUBU:  e.word = pack_r(rs, rt, rd, 5'd0, FN_SUBU);
      M_AND:   e.word = pack_r(rs, rt, rd, 5'd0, FN_AND);
      M_OR:    e.word = pack_r(rs, rt, rd, 5'd0, FN_OR);
      M_XOR:   e.word = pack_r(rs, rt, rd, 5'd0, FN_XOR);
      M_NOR:   e.word = pack_r(rs, rt, rd, 5'd0, FN_NOR);
      M_SLT:   e.word = pack_r(rs, rt, rd, 5'd0, FN_SLT);
      M_SLTU:  e.word = pack_r(rs, rt, rd, 5'd0, FN_SLTU);
      M_SLL:   e.word = pack_r(5'd0, rt, rd, shamt, FN_SLL);
      M_SRL:   e.word = pack_r(5'd0, rt, rd, shamt, FN_SRL);
      M_SRA:   e.word = pack_r(5'd0, rt, rd, shamt, FN_SRA);
      M_JR:    e.word = pack_r(rs, 5'd0, 5'd0, 5'd0, FN_JR);
      M_ADDIU: e.word = pack_i(OP_ADDIU, rs, rt, imm);
      M_SLTI:  e.word = pack_i(OP_SLTI, rs, rt, imm);
      M_SLTIU: e.word = pack_i(OP_SLTIU, rs, rt, imm);
      M_ANDI:  e.word = pack_i(OP_ANDI, rs, rt, imm);
      M_ORI:   e.word = pack_i(OP_ORI, rs, rt, imm);
      M_XORI:  e.word = pack_i(OP_XORI, rs, rt, imm);
      M_LUI:   e.word = pack_i(OP_LUI, 5'd0, rt, imm);
      M_LW:    e.word = pack_i(OP_LW, rs, rt, imm);
      M_SW:    e.word = pack_i(OP_SW, rs, rt, imm);
      M_LB:    e.word = pack_i(OP_LB, rs, rt, imm);
      M_LBU:   e.word = pack_i(OP_LBU, rs, rt, imm);
      M_SB:    e.word = pack_i(OP_SB, rs, rt, imm);
      M_BEQ:   e.word = pack_i(OP_BEQ, rs, rt, imm);
      M_BNE:   e.word = pack_i(OP_BNE, rs, rt, imm);
      M_BLEZ:  e.word = pack_i(OP_BLEZ, rs, 5'd0, imm);
      M_BGTZ:  e.word = pack_i(OP_BGTZ, rs, 5'd0, imm);
      M_BLTZ:  e.word = pack_i(OP_REGIMM, rs, RT_BLTZ, imm);
      M_BGEZ:  e.word = pack_i(OP_REGIMM, rs, RT_BGEZ, imm);
      M_J:     e.word = {OP_J, target};
      M_JAL:   e.word = {OP_JAL, target};
      default: begin
        e.valid = 1'b0;
        e.word  = 32'h0000_0000;
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/instr_stream_encoder_fifo.sv
// instr_word_fifo: small synchronous FIFO holding {address, word} pairs
// between the encode stage and the instruction-memory write port.
module instr_word_fifo #(
  parameter int WIDTH = 44,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // A push into a full FIFO is dropped even when a pop happens in the same cycle.
  assign push_ok_s = push && (count_r != FULL_CNT);
  assign pop_ok_s  = pop && (count_r != '0);
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// instr_stream_encoder: packs symbolic instructions into MIPS words and writes
// them sequentially to IMEM. Optional macro ENCODER_PCREL_EN: branch Imm is absolute.
module instr_stream_encoder #(
  parameter int AWIDTH = 12,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [5:0]        mnem,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [AWIDTH-1:0] word_count
);
  import instr_stream_encoder_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_e              state_r;
  logic [AWIDTH-1:0]   addr_r;
  logic                err_r;
  logic [AWIDTH-1:0]   wcount_r;

  logic [15:0]         imm_eff_s;
  enc_t                enc_s;
  logic                accept_s;
  logic                push_s;
  logic                pop_s;
  logic [CW-1:0]       fifo_count_s;
  logic                empty_s;
  logic [AWIDTH+31:0]  head_s;

  // Encode stage: branch offsets are optionally rebased against the slot address.
  always_comb begin
`ifdef ENCODER_PCREL_EN
    if (is_branch(mnem)) begin
      imm_eff_s = imm - 16'(addr_r) - 16'd1;
    end else begin
      imm_eff_s = imm;
    end
`else
    imm_eff_s = imm;
`endif
  end

  assign enc_s    = encode_instr(mnem, rs, rt, rd, shamt, imm_eff_s, target);
  assign in_ready = (state_r == ST_RUN) && (fifo_count_s < DEPTH_C);
  assign accept_s = in_valid && in_ready;
  assign push_s   = accept_s && enc_s.valid;
  assign pop_s    = !empty_s && mem_ready;

  instr_word_fifo #(
    .WIDTH (AWIDTH + 32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .din   ({addr_r, enc_s.word}),
    .pop   (pop_s),
    .dout  (head_s),
    .count (fifo_count_s),
    .empty (empty_s)
  );

  assign mem_we     = !empty_s;
  assign mem_addr   = empty_s ? '0 : head_s[AWIDTH+31:32];
  assign mem_data   = empty_s ? 32'h0000_0000 : head_s[31:0];
  assign busy       = (state_r != ST_IDLE);
  assign done       = (state_r == ST_DONE);
  assign err        = err_r;
  assign word_count = wcount_r;

  // Run-control FSM with the write-address counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      addr_r  <= '0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_RUN;
            addr_r  <= base_addr;
            err_r   <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            // Invalid mnemonics are swallowed without taking an address slot.
            if (enc_s.valid) begin
              addr_r <= addr_r + AWIDTH'(1);
            end else begin
              err_r <= 1'b1;
            end
            if (in_last) begin
              state_r <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (empty_s) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Words retired to IMEM since the last Start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcount_r <= '0;
    end else if ((state_r == ST_IDLE) && start) begin
      wcount_r <= '0;
    end else if (pop_s) begin
      wcount_r <= wcount_r + AWIDTH'(1);
    end
  end

endmodule
